// File: rtl/data_memory_wait.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_wait
// Purpose  : Word-addressed data memory with a fixed multi-cycle access wait.
//            A request is latched in IDLE, then held in BUSY for LATENCY
//            cycles. The access is performed on the edge that enters DONE.
//            DONE lasts one cycle, and the requester sees ready high in it.
//            Out-of-range accesses are suppressed. A read that is out of
//            range returns zero. For any out-of-range access, addrError
//            pulses high during DONE.
// Ports    : clk        - single clock; all state updates on rising edge
//            rst        - asynchronous active-high reset
//            readSig    - read request
//            writeSig   - write request (wins when both are high)
//            address    - 32-bit byte address
//            dataIn     - write data (DATA_W bits)
//            dataOut    - registered read data (DATA_W bits)
//            ready      - access complete / idle; requester stalls while low
//            addrError  - one-cycle pulse on an out-of-range access
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_wait #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 64,
  parameter int unsigned BASE_ADDR = 1024,
  parameter int          LATENCY   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              readSig,
  input  logic              writeSig,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              ready,
  output logic              addrError
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Window bounds are kept 33 bits wide so that a window ending exactly at
  // 2^32 does not wrap around.
  localparam logic [32:0] LO_ADDR  = 33'(BASE_ADDR);
  localparam logic [32:0] HI_ADDR  = 33'(BASE_ADDR) + 33'(DEPTH * BYTES);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [3:0]        count;
  logic [31:0]       lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_write;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              request;
  logic              accept;
  logic              finish;
  logic              in_range;
  logic [32:0]       offset;
  logic [IDX_W-1:0]  index;

  assign request = readSig | writeSig;
  assign accept  = (state == IDLE) && request;
  // The access is performed on the same edge that moves BUSY to DONE.
  assign finish  = (state == BUSY) && (count == 4'd0);

  // Range and index are derived from the latched address only. This means
  // that input changes during BUSY have no effect on the access.
  assign in_range = ({1'b0, lat_addr} >= LO_ADDR) && ({1'b0, lat_addr} < HI_ADDR);
  assign offset   = {1'b0, lat_addr} - LO_ADDR;
  assign index    = IDX_W'(offset >> OFF_W);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and ready
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          next_state = BUSY;
        end else begin
          ready = 1'b1;
        end
      end
      BUSY: begin
        if (count == 4'd0) begin
          next_state = DONE;
        end
      end
      DONE: begin
        // Requests present here are ignored; they are taken up in IDLE.
        ready      = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch and wait counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= 4'd0;
      lat_addr  <= 32'd0;
      lat_data  <= '0;
      lat_write <= 1'b0;
    end else if (accept) begin
      count     <= CNT_INIT;
      lat_addr  <= address;
      lat_data  <= dataIn;
      lat_write <= writeSig;   // read+write together is treated as a write
    end else if ((state == BUSY) && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Read data and error pulse, both updated on the edge that enters DONE
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataOut   <= '0;
      addrError <= 1'b0;
    end else begin
      addrError <= finish && !in_range;
      if (finish && !lat_write) begin
        dataOut <= in_range ? mem[index] : '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage array; it is cleared on reset, so an aborted write leaves no trace
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (finish && lat_write && in_range) begin
      mem[index] <= lat_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_wait.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_wait
// Purpose  : Directed self-checking bench for data_memory_wait. One
//            instance uses LATENCY=4 and a second instance uses LATENCY=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_wait;

  logic        clk;
  logic        rst;

  logic        rd0, wr0, rdy0, err0;
  logic [31:0] addr0, din0, dout0;
  logic        rd1, wr1, rdy1, err1;
  logic [31:0] addr1, din1, dout1;

  int errors = 0;
  int checks = 0;

  data_memory_wait #(.DATA_W(32), .DEPTH(64), .BASE_ADDR(1024), .LATENCY(4)) u_dut (
    .clk(clk), .rst(rst), .readSig(rd0), .writeSig(wr0), .address(addr0),
    .dataIn(din0), .dataOut(dout0), .ready(rdy0), .addrError(err0)
  );

  data_memory_wait #(.DATA_W(32), .DEPTH(64), .BASE_ADDR(1024), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .readSig(rd1), .writeSig(wr1), .address(addr1),
    .dataIn(din1), .dataOut(dout1), .ready(rdy1), .addrError(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit sel, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      rd1 = rd; wr1 = wr; addr1 = a; din1 = d;
    end else begin
      rd0 = rd; wr0 = wr; addr0 = a; din0 = d;
    end
  endtask

  function automatic logic get_rdy(input bit sel);
    return sel ? rdy1 : rdy0;
  endfunction

  function automatic logic get_err(input bit sel);
    return sel ? err1 : err0;
  endfunction

  function automatic logic [31:0] get_q(input bit sel);
    return sel ? dout1 : dout0;
  endfunction

  // Called one time unit after a rising edge. The request is held until
  // ready rises, and the number of ready-low samples is counted. The DONE
  // cycle and the following IDLE cycle are then checked.
  task automatic do_op(input string tag, input bit sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input int exp_low,
                       input logic [31:0] exp_q, input logic exp_err);
    int n;
    drv(sel, rd, wr, a, d);
    #1;
    n = 0;
    while (get_rdy(sel) !== 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check({tag, ":low_cycles"}, 32'(n), 32'(exp_low));
    check({tag, ":dataOut"}, get_q(sel), exp_q);
    check({tag, ":addrError"}, {31'd0, get_err(sel)}, {31'd0, exp_err});
    drv(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    check({tag, ":idle_err"}, {31'd0, get_err(sel)}, 32'd0);
    check({tag, ":idle_rdy"}, {31'd0, get_rdy(sel)}, 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drv(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    #12;
    check("reset:ready", {31'd0, rdy0}, 32'd1);
    check("reset:dataOut", dout0, 32'd0);
    check("reset:addrError", {31'd0, err0}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic write/read; offset bits are ignored.
    do_op("wr1024",   1'b0, 1'b0, 1'b1, 32'd1024, 32'h55555555, 5, 32'h00000000, 1'b0);
    do_op("rd1024",   1'b0, 1'b1, 1'b0, 32'd1024, 32'h0,        5, 32'h55555555, 1'b0);
    do_op("wr1030",   1'b0, 1'b0, 1'b1, 32'd1030, 32'hAAAAAAAA, 5, 32'h55555555, 1'b0);
    do_op("rd1028",   1'b0, 1'b1, 1'b0, 32'd1028, 32'h0,        5, 32'hAAAAAAAA, 1'b0);

    // Out-of-range accesses and the window edges.
    do_op("wr1280",   1'b0, 1'b0, 1'b1, 32'd1280, 32'hFFFF0000, 5, 32'hAAAAAAAA, 1'b1);
    do_op("rd1024b",  1'b0, 1'b1, 1'b0, 32'd1024, 32'h0,        5, 32'h55555555, 1'b0);
    do_op("rd1000",   1'b0, 1'b1, 1'b0, 32'd1000, 32'h0,        5, 32'h00000000, 1'b1);
    do_op("wr1276",   1'b0, 1'b0, 1'b1, 32'd1276, 32'h600DCAFE, 5, 32'h00000000, 1'b0);
    do_op("rd1276",   1'b0, 1'b1, 1'b0, 32'd1276, 32'h0,        5, 32'h600DCAFE, 1'b0);
    do_op("rd1023",   1'b0, 1'b1, 1'b0, 32'd1023, 32'h0,        5, 32'h00000000, 1'b1);

    // A request with both read and write high acts as a write.
    do_op("rd1028b",  1'b0, 1'b1, 1'b0, 32'd1028, 32'h0,        5, 32'hAAAAAAAA, 1'b0);
    do_op("both1036", 1'b0, 1'b1, 1'b1, 32'd1036, 32'hDEADBEEF, 5, 32'hAAAAAAAA, 1'b0);
    do_op("rd1036",   1'b0, 1'b1, 1'b0, 32'd1036, 32'h0,        5, 32'hDEADBEEF, 1'b0);

    // Inputs that change during BUSY must not alter the latched write.
    drv(1'b0, 1'b0, 1'b1, 32'd1040, 32'h11111111);
    @(posedge clk); #1;
    drv(1'b0, 1'b1, 1'b0, 32'd1044, 32'h22222222);
    n = 0;
    while (rdy0 !== 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check("busy_change:low_cycles", 32'(n), 32'd4);
    check("busy_change:dataOut", dout0, 32'hDEADBEEF);
    drv(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    do_op("rd1044",   1'b0, 1'b1, 1'b0, 32'd1044, 32'h0,        5, 32'h00000000, 1'b0);
    do_op("rd1040",   1'b0, 1'b1, 1'b0, 32'd1040, 32'h0,        5, 32'h11111111, 1'b0);

    // Reset in the second BUSY cycle aborts the write and clears memory.
    drv(1'b0, 1'b0, 1'b1, 32'd1032, 32'h12345678);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("abort:ready", {31'd0, rdy0}, 32'd1);
    check("abort:dataOut", dout0, 32'd0);
    check("abort:addrError", {31'd0, err0}, 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op("rd1032",   1'b0, 1'b1, 1'b0, 32'd1032, 32'h0,        5, 32'h00000000, 1'b0);
    do_op("rd1024c",  1'b0, 1'b1, 1'b0, 32'd1024, 32'h0,        5, 32'h00000000, 1'b0);

    // LATENCY=1: held back-to-back reads give ready high every third cycle.
    do_op("l1_wr1024", 1'b1, 1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, 2, 32'h00000000, 1'b0);
    do_op("l1_wr1028", 1'b1, 1'b0, 1'b1, 32'd1028, 32'h0BADF00D, 2, 32'h00000000, 1'b0);
    drv(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0);
    #1;
    check("l1_c0:ready", {31'd0, rdy1}, 32'd0);
    @(posedge clk); #1;
    check("l1_c1:ready", {31'd0, rdy1}, 32'd0);
    @(posedge clk); #1;
    check("l1_c2:ready", {31'd0, rdy1}, 32'd1);
    check("l1_c2:dataOut", dout1, 32'hCAFEF00D);
    drv(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0);
    @(posedge clk); #1;
    check("l1_c3:ready", {31'd0, rdy1}, 32'd0);
    @(posedge clk); #1;
    check("l1_c4:ready", {31'd0, rdy1}, 32'd0);
    @(posedge clk); #1;
    check("l1_c5:ready", {31'd0, rdy1}, 32'd1);
    check("l1_c5:dataOut", dout1, 32'h0BADF00D);
    check("l1_c5:addrError", {31'd0, err1}, 32'd0);
    drv(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_memory_wait.md
DATA_MEMORY_WAIT -- requirements
Module: data_memory_wait

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 64, number of words (power of two).
REQ-003 SHALL have parameter BASE_ADDR, default 1024, byte address mapped to word 0.
REQ-004 SHALL have parameter LATENCY, default 4, access wait cycles; legal range 1..15.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port readSig  input  1  read request.
REQ-008 SHALL have port writeSig  input  1  write request.
REQ-009 SHALL have port address  input  32  byte address.
REQ-010 SHALL have port dataIn  input  DATA_W  write data.
REQ-011 SHALL have port dataOut  output  DATA_W  registered read data.
REQ-012 SHALL have port ready  output  1  access complete / idle; requester stalls while low.
REQ-013 SHALL have port addrError  output  1  one-cycle pulse flagging an out-of-range access.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 IDLE: if readSig|writeSig at a rising edge, SHALL latch address, dataIn and op, load wait counter with LATENCY-1, and go to BUSY; otherwise stay IDLE.
REQ-016 BUSY: counter SHALL decrement each cycle; on the edge where counter==0, SHALL go to DONE and perform the latched access on that same edge.
REQ-017 DONE: SHALL last exactly one cycle, then go to IDLE; requests present during DONE SHALL be ignored.
REQ-018 ready SHALL be combinational: 1 when (IDLE and no request) or DONE; 0 otherwise.
REQ-019 Latency: ready SHALL rise in the (LATENCY+1)th cycle after the accepting edge, i.e. ready low for exactly LATENCY+1 cycles when the request is held.
REQ-020 Word index SHALL be (address - BASE_ADDR) >> log2(DATA_W/8); low byte-offset bits are ignored.
REQ-021 Access is in range iff BASE_ADDR <= address < BASE_ADDR + DEPTH*DATA_W/8.
REQ-022 In-range write SHALL update the indexed word; dataOut SHALL be unchanged.
REQ-023 In-range read SHALL load the indexed word into dataOut, holding it until the next completed read.
REQ-024 Out-of-range access SHALL suppress the write, set dataOut to 0 on reads, and pulse addrError high during DONE only.
REQ-025 readSig and writeSig both high SHALL be treated as a write.
REQ-026 Input changes during BUSY SHALL NOT affect the latched access.

Reset
REQ-027 rst high SHALL asynchronously force state IDLE, counter 0, dataOut 0, addrError 0, and all memory words 0.
REQ-028 Reset during BUSY SHALL abort the access; no memory word changes.
REQ-029 After rst falls, the first request SHALL be accepted on the first rising edge on which it is present in IDLE.

Verification (DATA_W=32, DEPTH=64, BASE_ADDR=1024, LATENCY=4 unless noted)
REQ-030 Write 0x55555555 @1024 held until ready -> ready low 5 cycles, then high; subsequent read @1024 -> dataOut 0x55555555 when ready rises, addrError 0.
REQ-031 Write 0xAAAAAAAA @1030, then read @1028 -> dataOut 0xAAAAAAAA (same word, offset bits ignored).
REQ-032 Write 0xFFFF0000 @1280 -> addrError pulses 1 cycle in DONE; read @1024 is unchanged; read @1000 -> dataOut 0 and addrError pulse.
REQ-033 Write 0x12345678 @1032, assert rst in 2nd BUSY cycle -> ready 1, dataOut 0 immediately; later read @1032 -> 0x00000000.
REQ-034 readSig=writeSig=1, dataIn 0xDEADBEEF @1036 -> dataOut unchanged; read @1036 -> 0xDEADBEEF.
REQ-035 LATENCY=1 override, back-to-back reads @1024/@1028 held -> ready high every 3rd cycle, each with correct data.
